ctrl_unit_pipe: RTL

CTRL_UNIT_PIPE -- requirements
Module: ctrl_unit_pipe

---
 rtl/rv_ctrl_pkg.sv | 95 +++++++++
 rtl/mdu_seq.sv | 67 ++++++
 rtl/ctrl_unit_pipe.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared RV32I/M control definitions used by the control unit, ALU and datapath.
//   - major opcode and funct7 constants
//   - ALU_CONTROL codes (bit 4 set = M-extension op)
//   - immediate-format and result-source selects
//   - divide sequencer states and the decoded control bundle
package rv_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'b00000,
    ALU_SUB    = 5'b00001,
    ALU_AND    = 5'b00100,
    ALU_OR     = 5'b00101,
    ALU_XOR    = 5'b00110,
    ALU_SLT    = 5'b01000,
    ALU_SLTU   = 5'b01001,
    ALU_SRL    = 5'b01101,
    ALU_SLL    = 5'b01110,
    ALU_SRA    = 5'b01111,
    ALU_MUL    = 5'b10000,
    ALU_MULH   = 5'b10001,
    ALU_MULHSU = 5'b10010,
    ALU_MULHU  = 5'b10011,
    ALU_DIV    = 5'b10100,
    ALU_DIVU   = 5'b10101,
    ALU_REM    = 5'b10110,
    ALU_REMU   = 5'b10111
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_UPC = 2'b11
  } res_src_e;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_BUSY = 1'b1
  } seq_state_e;

  typedef struct packed {
    logic [2:0] imm_src;
    logic [1:0] res_src;
    logic       mem_write;
    logic       alu_src;
    logic       alu_src_a;
    logic       reg_write;
    logic       jump;
    logic       jalr;
    logic       branch;
    logic [4:0] alu_op;
    logic [2:0] branch_f3;
    logic       illegal;
    logic       is_div;
  } ctrl_t;

  // funct3 -> ALU op for the plain (funct7 = 0) register and immediate forms
  function automatic alu_op_e alu_base(input logic [2:0] f3);
    alu_op_e op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mdu_seq.sv
// Divide/remainder sequencer.
//   clk, rst   : clock, synchronous active-high reset
//   div_in_e   : a legal divide/remainder currently sits in the E register
//   stall_req  : hold F/D and the E register this cycle
//   mdu_start  : one-cycle start pulse, first cycle the divide is in E
// The divide occupies E for DIV_LATENCY cycles: one IDLE cycle in which it
// arrives, then DIV_LATENCY-1 BUSY cycles timed by a down-counter.
module mdu_seq
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned DIV_LATENCY = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic div_in_e,
  output logic stall_req,
  output logic mdu_start
);

  localparam int unsigned CNT_W = $clog2(DIV_LATENCY);
  // BUSY cycles remaining after the first BUSY cycle
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LATENCY - 2);

  seq_state_e       state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEQ_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        SEQ_IDLE: begin
          if (div_in_e) begin
            state <= SEQ_BUSY;
            cnt   <= CNT_LOAD;
          end
        end
        SEQ_BUSY: begin
          if (cnt == '0) begin
            state <= SEQ_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= SEQ_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Last BUSY cycle releases the hold so E takes the next instruction on
  // that edge; a back-to-back divide then arrives in IDLE and pulses again.
  always_comb begin
    stall_req = 1'b0;
    mdu_start = 1'b0;
    if (state == SEQ_IDLE) begin
      stall_req = div_in_e;
      mdu_start = div_in_e;
    end else begin
      stall_req = (cnt != '0);
    end
  end

endmodule

// File: rtl/ctrl_unit_pipe.sv
// Pipelined RV32I(+M) control unit: D-stage decode and E-stage control register.
//   CLK, RST            : clock, synchronous active-high reset
//   OP, F3, F7          : opcode, funct3, funct7 of the D-stage instruction
//   VALID_D, FLUSH_E    : D holds a real instruction / load a bubble into E
//   IMM_SRC_D           : immediate format (combinational, D stage)
//   *_E                 : registered E-stage controls, ILLEGAL_E flags bad encodings
//   STALL_REQ           : hold F/D while a divide occupies E
//   MDU_START           : one-cycle pulse to the divider when a divide enters E
module ctrl_unit_pipe
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned ENABLE_M    = 1,
  parameter int unsigned DIV_LATENCY = 32,
  parameter int unsigned ALU_CTRL_W  = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [6:0]            OP,
  input  logic [2:0]            F3,
  input  logic [6:0]            F7,
  input  logic                  VALID_D,
  input  logic                  FLUSH_E,
  output logic [2:0]            IMM_SRC_D,
  output logic [1:0]            RES_SRC_E,
  output logic                  MEM_WRITE_E,
  output logic                  ALU_SRC_E,
  output logic                  ALU_SRC_A_E,
  output logic                  REG_WRITE_E,
  output logic                  JUMP_E,
  output logic                  JALR_E,
  output logic                  BRANCH_E,
  output logic [ALU_CTRL_W-1:0] ALU_CONTROL_E,
  output logic [2:0]            BRANCH_F3_E,
  output logic                  ILLEGAL_E,
  output logic                  STALL_REQ,
  output logic                  MDU_START
);

  localparam ctrl_t CTRL_NOP = '0;

  ctrl_t dec;
  ctrl_t e_q;
  logic  hold;
  logic  mdu_start_w;

  always_comb begin
    dec = CTRL_NOP;
    case (OP)
      OPC_LOAD: begin
        dec.illegal   = (F3 == 3'b011) || (F3[2:1] == 2'b11);
        dec.imm_src   = IMM_I;
        dec.res_src   = RES_MEM;
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALU_ADD;
        dec.reg_write = 1'b1;
      end
      OPC_STORE: begin
        dec.illegal   = (F3 > 3'b010);
        dec.imm_src   = IMM_S;
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALU_ADD;
      end
      OPC_OP_IMM: begin
        dec.imm_src   = IMM_I;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = alu_base(F3);
        if (F3 == 3'b001) begin
          dec.illegal = (F7 != F7_BASE);
        end else if (F3 == 3'b101) begin
          if (F7 == F7_ALT) dec.alu_op = ALU_SRA;
          else              dec.illegal = (F7 != F7_BASE);
        end
      end
      OPC_OP: begin
        dec.reg_write = 1'b1;
        case (F7)
          F7_BASE: dec.alu_op = alu_base(F3);
          F7_ALT: begin
            if (F3 == 3'b000)      dec.alu_op  = ALU_SUB;
            else if (F3 == 3'b101) dec.alu_op  = ALU_SRA;
            else                   dec.illegal = 1'b1;
          end
          F7_MULDIV: begin
            if (ENABLE_M != 0) begin
              dec.alu_op = {2'b10, F3};
              dec.is_div = F3[2];
            end else begin
              dec.illegal = 1'b1;
            end
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        dec.imm_src   = IMM_U;
        dec.alu_src   = 1'b1;
        dec.alu_src_a = 1'b1;
        dec.alu_op    = ALU_ADD;
        dec.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        dec.imm_src   = IMM_U;
        dec.res_src   = RES_UPC;
        dec.reg_write = 1'b1;
      end
      OPC_BRANCH: begin
        dec.imm_src   = IMM_B;
        dec.branch    = 1'b1;
        dec.branch_f3 = F3;
        case (F3[2:1])
          2'b00:   dec.alu_op  = ALU_SUB;
          2'b10:   dec.alu_op  = ALU_SLT;
          2'b11:   dec.alu_op  = ALU_SLTU;
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_JAL: begin
        dec.imm_src   = IMM_J;
        dec.jump      = 1'b1;
        dec.res_src   = RES_PC4;
        dec.reg_write = 1'b1;
      end
      OPC_JALR: begin
        dec.illegal   = (F3 != 3'b000);
        dec.imm_src   = IMM_I;
        dec.jump      = 1'b1;
        dec.jalr      = 1'b1;
        dec.res_src   = RES_PC4;
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALU_ADD;
        dec.reg_write = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    // An illegal encoding collapses to a lone flag so nothing downstream
    // writes, jumps or branches on a half-decoded instruction.
    if (dec.illegal) begin
      dec         = CTRL_NOP;
      dec.illegal = 1'b1;
    end
  end

  assign IMM_SRC_D = dec.imm_src;

  // Hold outranks flush: once the divider has been started the divide must
  // stay in E until its last cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      e_q <= CTRL_NOP;
    end else if (!hold) begin
      e_q <= (VALID_D && !FLUSH_E) ? dec : CTRL_NOP;
    end
  end

  generate
    if (ENABLE_M != 0) begin : g_mdu
      mdu_seq #(
        .DIV_LATENCY (DIV_LATENCY)
      ) u_mdu_seq (
        .clk       (CLK),
        .rst       (RST),
        .div_in_e  (e_q.is_div),
        .stall_req (hold),
        .mdu_start (mdu_start_w)
      );
    end else begin : g_no_mdu
      logic div_unused;
      assign div_unused  = e_q.is_div;
      assign hold        = 1'b0;
      assign mdu_start_w = 1'b0;
    end
  endgenerate

  assign STALL_REQ     = hold;
  assign MDU_START     = mdu_start_w;
  assign RES_SRC_E     = e_q.res_src;
  assign MEM_WRITE_E   = e_q.mem_write;
  assign ALU_SRC_E     = e_q.alu_src;
  assign ALU_SRC_A_E   = e_q.alu_src_a;
  assign REG_WRITE_E   = e_q.reg_write;
  assign JUMP_E        = e_q.jump;
  assign JALR_E        = e_q.jalr;
  assign BRANCH_E      = e_q.branch;
  assign ALU_CONTROL_E = ALU_CTRL_W'(e_q.alu_op);
  assign BRANCH_F3_E   = e_q.branch_f3;
  assign ILLEGAL_E     = e_q.illegal;

endmodule
